regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single Regfile write port between the in-order pipeline WB stage (port P) and a
//  long-latency unit (port B: divider/serial-load return) that completes out of band.
//  P always wins. B results wait in a 1-entry buffer. A wait counter requests a pipeline
//  stall if B starves. ID reads the buffer for forwarding and squash-on-WAW.
//  Sits between MEM/WB, the multi-cycle unit, Regfile write port and the stall controller.
// PARAMETERS
//  MAX_WAIT  4  cycles a buffered B write may wait before stall_req_o is raised (1..15)
//  WAIT_W    4  width of the wait counter; must hold MAX_WAIT
// PORTS
//  clk        in   1   clock; all state updates on posedge
//  rst        in   1   synchronous, active-high reset
//  p_we       in   1   pipeline WB write enable; never back-pressured
//  p_waddr    in   5   `RegAddrBus pipeline WB destination
//  p_wdata    in   32  `RegBus pipeline WB data
//  b_valid    in   1   B result valid
//  b_ready    out  1   B accepted this cycle when b_valid&&b_ready
//  b_waddr    in   5   B destination
//  b_wdata    in   32  B data
//  we_o       out  1   to Regfile we
//  waddr_o    out  5   to Regfile waddr
//  wdata_o    out  32  to Regfile wdata
//  q_addr1    in   5   ID read address 1 (mirrors raddr1)
//  q_hit1     out  1   buffered write pending to q_addr1
//  q_data1    out  32  buffered data for q_addr1 (ZeroWord when !q_hit1)
//  q_addr2    in   5   ID read address 2
//  q_hit2     out  1   as q_hit1
//  q_data2    out  32  as q_data1
//  stall_req_o out 1   registered stall request to pipeline ctrl
//  squash_o   out  1   1-cycle pulse: a B write was dropped by WAW
// BEHAVIOUR
//  - "P slot busy" = p_we && p_waddr!=0. Writes to r0 are never issued, buffered or hit.
//  - Reset: buf_valid=0, wait_cnt=0, stall_req_o=0.
//  - While rst, we_o=0, waddr_o=0, wdata_o=0, b_ready=0, q_hit*=0, squash_o=0.
//  - Write-port mux (combinational, zero latency; Regfile writes at the edge):
//    - If P busy, output P.
//    - Else if buf_valid, output buf.
//    - Else if b_valid with b_waddr!=0, output B directly (flow-through).
//    - Otherwise we_o=0.
//  - b_ready = !buf_valid (combinational from state, independent of b_valid).
//  - B accept when b_valid&&b_ready:
//    - waddr==0: dropped silently.
//    - P busy with same addr: WAW. B is older, so drop it and pulse squash_o.
//    - P busy with different addr: capture into buf.
//    - P not busy: flow-through, no capture.
//  - Buffered entry:
//    - Drains in any cycle P is not busy; buf_valid clears at that edge.
//    - Squashed (buf_valid clears, squash_o pulses) if P busy with p_waddr==buf_waddr.
//    - A drain and a new capture cannot occur in the same cycle (b_ready=0 while full).
//  - wait_cnt: while buf_valid and not drained, increments and saturates at MAX_WAIT.
//    Clears on drain, squash or reset.
//  - stall_req_o:
//    - Set at the edge where wait_cnt reaches MAX_WAIT with buf still valid.
//    - Cleared at the edge where buf drains or is squashed.
//    - Stall ctrl turns WB into bubbles from the next cycle. P still wins any cycle it writes.
//  - q_hit*/q_data*: combinational.
//    - Hit = buf_valid && q_addr==buf_waddr && q_addr!=0.
//    - Still asserted in the drain cycle.
//    - Flow-through B data is not forwarded; the ID stage treats an in-flight B dest as busy.
//  - Reset mid-operation: a pending buffered write is discarded, never written.
// STRUCTURE
//  - Use the shared defines.vh macros `RegAddrBus, `RegBus, `ZeroWord, `NOPRegAddr, `WriteEnable.
//    Add `WriteDisable if it is missing.
//  - Sub-module rf_wb_buffer holds the 1-entry buffer and its q_hit/q_data compare logic.
//  - Top level holds the mux, wait counter and stall/squash logic.
// TESTING
//  1. rst held 2 cycles with b_valid=1 -> we_o=0, b_ready=0, stall_req_o=0; after release
//     buf_valid=0.
//  2. p_we=0, B (r5, 0xDEADBEEF) -> same cycle we_o=1, waddr_o=5, wdata_o=0xDEADBEEF;
//     b_ready stays 1.
//  3. P writes r3 and B (r7, 0x11) arrives same cycle -> P on port, B buffered, b_ready=0,
//     q_hit1=1 for q_addr1=7; next idle P cycle writes r7=0x11.
//  4. B buffered r9, P busy on other regs for 6 cycles with MAX_WAIT=4 -> stall_req_o rises
//     after 4 waiting edges; first p_we=0 cycle drains r9; stall_req_o low the next cycle.
//  5. B buffered r4, then P writes r4=0x22 -> squash_o pulses, buf_valid=0, Regfile r4 ends
//     0x22, never overwritten.
//  6. B to r0 and P to r0 -> we_o stays 0, no buffer, q_hit*=0, squash_o=0.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared definitions for the Regfile write-back arbiter slice: bus macros,
// default parameters, the write-port source selector and an address helper.

`ifndef REGFILE_WB_ARBITER_DEFINES
`define REGFILE_WB_ARBITER_DEFINES
`define RegAddrBus   4:0
`define RegBus       31:0
`define ZeroWord     32'h0000_0000
`define NOPRegAddr   5'b00000
`define WriteEnable  1'b1
`define WriteDisable 1'b0
`endif

package regfile_wb_arbiter_pkg;

    // Default wait budget before a starving buffered write asks for a stall
    localparam int MAX_WAIT_DEF = 4;
    localparam int WAIT_W_DEF   = 4;

    // Which source currently owns the single Regfile write port
    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_P    = 2'd1,
        SEL_BUF  = 2'd2,
        SEL_B    = 2'd3
    } wrSel_e;

    // r0 is hardwired, so a write to it never counts as a real write
    function automatic logic isLiveAddr(input logic [`RegAddrBus] addr);
        return addr != `NOPRegAddr;
    endfunction

endpackage

// File: rtl/rf_wb_buffer.sv
// One-entry holding buffer for a long-latency result that lost the write
// port to the pipeline, plus the ID-stage lookup used for forwarding.

module rf_wb_buffer
    import regfile_wb_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              capture_i,
    input  logic              clear_i,
    input  logic [`RegAddrBus] capAddr_i,
    input  logic [`RegBus]     capData_i,
    output logic              valid_o,
    output logic [`RegAddrBus] waddr_o,
    output logic [`RegBus]     wdata_o,
    input  logic [`RegAddrBus] qAddr1_i,
    input  logic [`RegAddrBus] qAddr2_i,
    output logic              qHit1_o,
    output logic [`RegBus]     qData1_o,
    output logic              qHit2_o,
    output logic [`RegBus]     qData2_o
);

    logic              valid_q;
    logic [`RegAddrBus] addr_q;
    logic [`RegBus]     data_q;

    // Hold the entry until it is drained or squashed; a reset discards it unwritten
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            addr_q  <= `NOPRegAddr;
            data_q  <= `ZeroWord;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (capture_i) begin
            valid_q <= 1'b1;
            addr_q  <= capAddr_i;
            data_q  <= capData_i;
        end
    end

    // Forwarding lookup; stays visible in the drain cycle so ID never sees a gap
    always_comb begin
        qHit1_o  = 1'b0;
        qHit2_o  = 1'b0;
        qData1_o = `ZeroWord;
        qData2_o = `ZeroWord;
        if (!rst && valid_q) begin
            qHit1_o = isLiveAddr(qAddr1_i) && (qAddr1_i == addr_q);
            qHit2_o = isLiveAddr(qAddr2_i) && (qAddr2_i == addr_q);
        end
        if (qHit1_o) qData1_o = data_q;
        if (qHit2_o) qData2_o = data_q;
    end

    assign valid_o = valid_q;
    assign waddr_o = addr_q;
    assign wdata_o = data_q;

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the Regfile write port between the pipeline WB stage (always wins)
// and an out-of-band long-latency unit whose results wait in a 1-entry buffer.
// A wait counter raises a registered stall request if that buffer starves.

module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEF,
    parameter int WAIT_W   = WAIT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p_we,
    input  logic [`RegAddrBus] p_waddr,
    input  logic [`RegBus]     p_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [`RegAddrBus] b_waddr,
    input  logic [`RegBus]     b_wdata,
    output logic              we_o,
    output logic [`RegAddrBus] waddr_o,
    output logic [`RegBus]     wdata_o,
    input  logic [`RegAddrBus] q_addr1,
    output logic              q_hit1,
    output logic [`RegBus]     q_data1,
    input  logic [`RegAddrBus] q_addr2,
    output logic              q_hit2,
    output logic [`RegBus]     q_data2,
    output logic              stall_req_o,
    output logic              squash_o
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MAX_WAIT);

    logic              pBusy;
    logic              bAccept;
    logic              bLive;
    logic              bCapture;
    logic              bWaw;
    logic              bufValid;
    logic [`RegAddrBus] bufAddr;
    logic [`RegBus]     bufData;
    logic              bufDrain;
    logic              bufSquash;
    wrSel_e            wrSel;

    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              stallReq_q, stallReq_d;

    assign pBusy   = p_we && isLiveAddr(p_waddr);
    assign bLive   = isLiveAddr(b_waddr);
    assign b_ready = !rst && !bufValid;
    assign bAccept = b_valid && b_ready;

    // B only needs holding when P owns the port and targets a different register;
    // on a matching address the older B result is dead and gets dropped
    assign bCapture  = bAccept && bLive && pBusy && (p_waddr != b_waddr);
    assign bWaw      = bAccept && bLive && pBusy && (p_waddr == b_waddr);
    assign bufDrain  = bufValid && !pBusy;
    assign bufSquash = bufValid && pBusy && (p_waddr == bufAddr);

    rf_wb_buffer u_buffer (
        .clk       (clk),
        .rst       (rst),
        .capture_i (bCapture),
        .clear_i   (bufDrain || bufSquash),
        .capAddr_i (b_waddr),
        .capData_i (b_wdata),
        .valid_o   (bufValid),
        .waddr_o   (bufAddr),
        .wdata_o   (bufData),
        .qAddr1_i  (q_addr1),
        .qAddr2_i  (q_addr2),
        .qHit1_o   (q_hit1),
        .qData1_o  (q_data1),
        .qHit2_o   (q_hit2),
        .qData2_o  (q_data2)
    );

    // Priority select for the write port: pipeline, then buffer, then flow-through B
    always_comb begin
        wrSel = SEL_NONE;
        if (pBusy)                 wrSel = SEL_P;
        else if (bufValid)         wrSel = SEL_BUF;
        else if (b_valid && bLive) wrSel = SEL_B;
    end

    // Drive the Regfile port from the selected source; nothing is written in reset
    always_comb begin
        we_o    = `WriteDisable;
        waddr_o = `NOPRegAddr;
        wdata_o = `ZeroWord;
        if (!rst) begin
            unique case (wrSel)
                SEL_P: begin
                    we_o    = `WriteEnable;
                    waddr_o = p_waddr;
                    wdata_o = p_wdata;
                end
                SEL_BUF: begin
                    we_o    = `WriteEnable;
                    waddr_o = bufAddr;
                    wdata_o = bufData;
                end
                SEL_B: begin
                    we_o    = `WriteEnable;
                    waddr_o = b_waddr;
                    wdata_o = b_wdata;
                end
                default: begin
                    we_o    = `WriteDisable;
                end
            endcase
        end
    end

    assign squash_o = !rst && (bWaw || bufSquash);

    // Count how long a buffered write has been starved, and request a stall once
    // it has waited its budget; both release as soon as the entry leaves
    always_comb begin
        waitCnt_d  = waitCnt_q;
        stallReq_d = stallReq_q;
        if (bufDrain || bufSquash) begin
            waitCnt_d  = '0;
            stallReq_d = 1'b0;
        end else if (bufValid) begin
            if (waitCnt_q != WAIT_LIMIT) waitCnt_d = waitCnt_q + WAIT_W'(1);
            if (waitCnt_d == WAIT_LIMIT) stallReq_d = 1'b1;
        end
    end

    // Wait counter and stall request registers
    always_ff @(posedge clk) begin
        if (rst) begin
            waitCnt_q  <= '0;
            stallReq_q <= 1'b0;
        end else begin
            waitCnt_q  <= waitCnt_d;
            stallReq_q <= stallReq_d;
        end
    end

    assign stall_req_o = stallReq_q;

endmodule
